flush_sequencer: RTL and testbench

- Parametrised successor to the core flush controller.
- Generates the same-cycle pipeline flush/PC-sync controls for mispredict, FENCE, FENCE.I, SFENCE.VMA, CSR/commit flush and exception/eret/debug events.
- Sequences level-held flush requests to NumTargets cache/buffer targets (target 0 = DCache, 1 = ICache, higher = L2/etc.), with a per-target outstanding mask and an ack timeout.
- Sits between commit/CSR stages and the cache subsystem.

---
 rtl/flush_sequencer.sv | 164 ++++++++++++++++
 tb/tb_flush_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flush_sequencer.sv
// flush_sequencer: same-cycle pipeline flush / PC-sync controls plus a
// sequencer that issues level-held flush requests to NumTargets cache and
// buffer targets (0 = DCache, 1 = ICache, higher = L2 etc.).  Each target
// stays requested until it acks; a WAIT watchdog aborts stuck flushes.
//
//   state | meaning
//   IDLE  | no cache flush outstanding
//   WAIT  | at least one target requested, waiting for acks or timeout
//   DRAIN | one settle cycle after the last ack (or abort) before IDLE

module flush_sequencer #(
  parameter int unsigned               NumTargets = 2,
  parameter logic [NumTargets-1:0]     FenceMask  = 'b01,
  parameter logic [NumTargets-1:0]     FenceIMask = 'b11,
  parameter int unsigned               AckTimeout = 1024,
  parameter bit                        DebugEn    = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mispredict_i,
  input  logic                  fence_i,
  input  logic                  fence_i_i,
  input  logic                  sfence_vma_i,
  input  logic                  flush_csr_i,
  input  logic                  flush_commit_i,
  input  logic                  ex_valid_i,
  input  logic                  eret_i,
  input  logic                  set_debug_pc_i,
  input  logic                  halt_csr_i,
  input  logic [NumTargets-1:0] flush_ack_i,
  output logic [NumTargets-1:0] flush_req_o,
  output logic                  set_pc_commit_o,
  output logic                  flush_if_o,
  output logic                  flush_unissued_o,
  output logic                  flush_id_o,
  output logic                  flush_ex_o,
  output logic                  flush_bp_o,
  output logic                  flush_tlb_o,
  output logic                  halt_o,
  output logic                  halt_frontend_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [NumTargets-1:0] timeout_mask_o
);

  // Counter only needs to reach AckTimeout-1; with the timeout disabled it
  // just saturates and is never compared.
  localparam bit          TimeoutEn = (AckTimeout > 0);
  localparam int unsigned CntW      = (AckTimeout > 2) ? $clog2(AckTimeout) : 1;
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(AckTimeout - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NumTargets-1:0] out_q, out_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  fencei_q, fencei_d;
  logic [NumTargets-1:0] tmask_q, tmask_d;
  logic                  tout_q, tout_d;

  logic [NumTargets-1:0] new_mask;
  logic [NumTargets-1:0] remain;

  assign new_mask = (fence_i   ? FenceMask  : '0)
                  | (fence_i_i ? FenceIMask : '0);
  assign remain   = (out_q & ~flush_ack_i) | new_mask;

  // State and sequencer registers; reset abandons any flush in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      out_q    <= '0;
      cnt_q    <= '0;
      fencei_q <= 1'b0;
      tmask_q  <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      fencei_q <= fencei_d;
      tmask_q  <= tmask_d;
      tout_q   <= tout_d;
    end
  end

  // Next-state: accept new fence masks, retire acked targets, run the watchdog.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    fencei_d = fencei_q;
    tmask_d  = tmask_q;
    tout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|new_mask) begin
          state_d = WAIT;
          out_d   = new_mask;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (remain == '0) begin
          state_d = DRAIN;
          out_d   = '0;
        end else if (|new_mask) begin
          // A fresh fence restarts the watchdog for the merged set.
          out_d = remain;
          cnt_d = '0;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          tmask_d = out_q;
          tout_d  = 1'b1;
          out_d   = '0;
          state_d = DRAIN;
        end else begin
          out_d = remain;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // A fence landing in the drain cycle is not dropped.
        if (|new_mask) begin
          state_d = WAIT;
          out_d   = new_mask;
          cnt_d   = '0;
        end else begin
          state_d  = IDLE;
          fencei_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((|new_mask) && fence_i_i) fencei_d = 1'b1;
  end

  // Outputs: pipeline controls are purely combinational on the event inputs.
  always_comb begin
    logic exc_evt;
    logic fence_evt;
    exc_evt   = ex_valid_i | eret_i | (DebugEn & set_debug_pc_i);
    fence_evt = fence_i | fence_i_i | sfence_vma_i | flush_csr_i | flush_commit_i;

    set_pc_commit_o  = fence_evt & ~exc_evt;
    flush_if_o       = mispredict_i | fence_evt | exc_evt;
    flush_unissued_o = mispredict_i | fence_evt | exc_evt;
    flush_id_o       = fence_evt | exc_evt;
    flush_ex_o       = fence_evt | exc_evt;
    flush_bp_o       = exc_evt;
    flush_tlb_o      = sfence_vma_i;

    busy_o           = (state_q != IDLE);
    halt_o           = halt_csr_i | (state_q != IDLE);
    halt_frontend_o  = fencei_q;
    flush_req_o      = out_q;
    timeout_o        = tout_q;
    timeout_mask_o   = tmask_q;
  end

endmodule

// File: tb/tb_flush_sequencer.sv
// Bench for flush_sequencer: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model.

module tb_flush_sequencer;

  localparam int NT = 2;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          mispredict_i, fence_i, fence_i_i, sfence_vma_i;
  logic          flush_csr_i, flush_commit_i, ex_valid_i, eret_i;
  logic          set_debug_pc_i, halt_csr_i;
  logic [NT-1:0] flush_ack_i;
  logic [NT-1:0] flush_req_o, timeout_mask_o;
  logic          set_pc_commit_o, flush_if_o, flush_unissued_o, flush_id_o;
  logic          flush_ex_o, flush_bp_o, flush_tlb_o, halt_o, halt_frontend_o;
  logic          busy_o, timeout_o;

  flush_sequencer #(
    .NumTargets (NT),
    .FenceMask  (2'b01),
    .FenceIMask (2'b11),
    .AckTimeout (TO),
    .DebugEn    (1'b1)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .mispredict_i     (mispredict_i),
    .fence_i          (fence_i),
    .fence_i_i        (fence_i_i),
    .sfence_vma_i     (sfence_vma_i),
    .flush_csr_i      (flush_csr_i),
    .flush_commit_i   (flush_commit_i),
    .ex_valid_i       (ex_valid_i),
    .eret_i           (eret_i),
    .set_debug_pc_i   (set_debug_pc_i),
    .halt_csr_i       (halt_csr_i),
    .flush_ack_i      (flush_ack_i),
    .flush_req_o      (flush_req_o),
    .set_pc_commit_o  (set_pc_commit_o),
    .flush_if_o       (flush_if_o),
    .flush_unissued_o (flush_unissued_o),
    .flush_id_o       (flush_id_o),
    .flush_ex_o       (flush_ex_o),
    .flush_bp_o       (flush_bp_o),
    .flush_tlb_o      (flush_tlb_o),
    .halt_o           (halt_o),
    .halt_frontend_o  (halt_frontend_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o),
    .timeout_mask_o   (timeout_mask_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: set of targets still owed an ack, whether a flush
  // episode is open, whether the one-cycle settle is pending, and how many
  // waiting cycles have elapsed since the last fence.
  logic [NT-1:0] m_owed;
  bit            m_open, m_settle, m_fencei, m_pulse;
  logic [NT-1:0] m_abort_set;
  int            m_age;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic m_reset();
    m_owed = '0; m_open = 0; m_settle = 0; m_fencei = 0;
    m_pulse = 0; m_abort_set = '0; m_age = 0;
  endtask

  task automatic m_update();
    logic [NT-1:0] fresh, left;
    fresh = (fence_i ? 2'b01 : 2'b00) | (fence_i_i ? 2'b11 : 2'b00);
    left  = (m_owed & ~flush_ack_i) | fresh;
    m_pulse = 0;
    if (m_open) begin
      if (left == 0) begin
        m_owed = 0; m_open = 0; m_settle = 1;
      end else if (fresh != 0) begin
        m_owed = left; m_age = 0;
      end else if (m_age + 1 == TO) begin
        m_abort_set = m_owed; m_pulse = 1;
        m_owed = 0; m_open = 0; m_settle = 1;
      end else begin
        m_owed = left; m_age++;
      end
    end else if (fresh != 0) begin
      m_owed = fresh; m_open = 1; m_settle = 0; m_age = 0;
    end else if (m_settle) begin
      m_settle = 0; m_fencei = 0;
    end
    if (fresh != 0 && fence_i_i) m_fencei = 1;
  endtask

  task automatic check_model();
    bit exc, fl, busy;
    exc  = ex_valid_i | eret_i | set_debug_pc_i;
    fl   = fence_i | fence_i_i | sfence_vma_i | flush_csr_i | flush_commit_i;
    busy = m_open | m_settle;
    chk("set_pc_commit", set_pc_commit_o, fl & !exc);
    chk("flush_if", flush_if_o, mispredict_i | fl | exc);
    chk("flush_unissued", flush_unissued_o, mispredict_i | fl | exc);
    chk("flush_id", flush_id_o, fl | exc);
    chk("flush_ex", flush_ex_o, fl | exc);
    chk("flush_bp", flush_bp_o, exc);
    chk("flush_tlb", flush_tlb_o, sfence_vma_i);
    chk("flush_req", flush_req_o, m_owed);
    chk("busy", busy_o, busy);
    chk("halt", halt_o, halt_csr_i | busy);
    chk("halt_frontend", halt_frontend_o, m_fencei);
    chk("timeout", timeout_o, m_pulse);
    chk("timeout_mask", timeout_mask_o, m_abort_set);
  endtask

  task automatic clr_in();
    mispredict_i = 0; fence_i = 0; fence_i_i = 0; sfence_vma_i = 0;
    flush_csr_i = 0; flush_commit_i = 0; ex_valid_i = 0; eret_i = 0;
    set_debug_pc_i = 0; halt_csr_i = 0; flush_ack_i = '0;
  endtask

  // Inputs for the current cycle are already applied and settled.
  task automatic step();
    check_model();
    @(posedge clk_i);
    m_update();
    #1;
  endtask

  initial begin
    clr_in();
    m_reset();
    rst_ni = 1'b0;
    #3;
    check_model();
    chk("reset_req", flush_req_o, 2'b00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Mispredict alone
    clr_in(); mispredict_i = 1; #1;
    chk("mp_if", flush_if_o, 1);
    chk("mp_id", flush_id_o, 0);
    chk("mp_setpc", set_pc_commit_o, 0);
    step();
    clr_in(); #1;
    chk("mp_busy", busy_o, 0);
    step();

    // FENCE, ack[0] at cycle 4
    clr_in(); fence_i = 1; #1; step();            // cycle 0
    for (int c = 1; c <= 3; c++) begin
      clr_in(); #1;
      chk("fence_req", flush_req_o, 2'b01);
      chk("fence_halt", halt_o, 1);
      step();
    end
    clr_in(); flush_ack_i = 2'b01; #1;
    chk("fence_req4", flush_req_o, 2'b01);
    step();                                        // cycle 4
    clr_in(); #1;
    chk("fence_drain", busy_o, 1);
    chk("fence_req5", flush_req_o, 2'b00);
    chk("fence_hfe", halt_frontend_o, 0);
    step();                                        // cycle 5
    clr_in(); #1;
    chk("fence_idle", busy_o, 0);
    step();                                        // cycle 6

    // FENCE.I, ack[1] at cycle 3, ack[0] at cycle 6
    clr_in(); fence_i_i = 1; #1; step();           // cycle 0
    for (int c = 1; c <= 7; c++) begin
      clr_in();
      if (c == 3) flush_ack_i = 2'b10;
      if (c == 6) flush_ack_i = 2'b01;
      #1;
      if (c == 2) chk("fi_req2", flush_req_o, 2'b11);
      if (c == 4) chk("fi_req4", flush_req_o, 2'b01);
      if (c == 7) chk("fi_req7", flush_req_o, 2'b00);
      chk("fi_hfe", halt_frontend_o, 1);
      step();
    end
    clr_in(); #1;
    chk("fi_idle", busy_o, 0);
    chk("fi_hfe8", halt_frontend_o, 0);
    step();

    // Timeout with no ack
    clr_in(); fence_i = 1; #1; step();             // cycle 0
    for (int c = 1; c <= 8; c++) begin clr_in(); #1; step(); end
    clr_in(); #1;
    chk("to_pulse", timeout_o, 1);
    chk("to_mask", timeout_mask_o, 2'b01);
    step();                                        // cycle 9
    clr_in(); #1;
    chk("to_pulse_end", timeout_o, 0);
    chk("to_idle", busy_o, 0);
    chk("to_mask_hold", timeout_mask_o, 2'b01);
    step();

    // Exception with CSR flush, then exception during WAIT
    clr_in(); ex_valid_i = 1; flush_csr_i = 1; #1;
    chk("ex_setpc", set_pc_commit_o, 0);
    chk("ex_bp", flush_bp_o, 1);
    step();
    clr_in(); fence_i_i = 1; #1; step();
    clr_in(); #1; step();
    clr_in(); eret_i = 1; #1; step();
    clr_in(); #1;
    chk("ex_wait_req", flush_req_o, 2'b11);
    step();

    // Reset in WAIT with req=11
    clr_in(); #1;
    rst_ni = 1'b0; #1;
    m_reset();
    check_model();
    chk("rst_req", flush_req_o, 2'b00);
    chk("rst_hfe", halt_frontend_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    clr_in(); flush_ack_i = 2'b11; #1; step();
    clr_in(); #1;
    chk("rst_stray", busy_o, 0);
    step();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      clr_in();
      mispredict_i   = ($urandom_range(0, 5) == 0);
      fence_i        = ($urandom_range(0, 11) == 0);
      fence_i_i      = ($urandom_range(0, 15) == 0);
      sfence_vma_i   = ($urandom_range(0, 9) == 0);
      flush_csr_i    = ($urandom_range(0, 9) == 0);
      flush_commit_i = ($urandom_range(0, 9) == 0);
      ex_valid_i     = ($urandom_range(0, 9) == 0);
      eret_i         = ($urandom_range(0, 15) == 0);
      set_debug_pc_i = ($urandom_range(0, 15) == 0);
      halt_csr_i     = ($urandom_range(0, 7) == 0);
      flush_ack_i[0] = ($urandom_range(0, 6) == 0);
      flush_ack_i[1] = ($urandom_range(0, 6) == 0);
      #1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
